prog_run_ctrl: RTL and testbench
================================

# prog_run_ctrl

Run-control state machine for the basic processor. It generalises the single-bit program-counter enable into a parametrised start/run/halt controller. It accepts the testbench `Start` handshake, sequences through `NUM_PROGS` programs, and drives the PC's count enable and load strobe. It also ends each run on processor `Done` or a cycle-budget timeout. It sits between the testbench and the program counter, alongside the instruction fetch.

## Interface
- `NUM_PROGS`, default 3: number of programs run back-to-back; ≥1.
- `PROG_W`, default `$clog2(NUM_PROGS)` (min 1): width of the program index.
- `CYC_W`, default 16: width of the cycle counter.
- `MAX_CYCLES`, default 16'hFFFF: cycle budget per run; `1 ≤ MAX_CYCLES ≤ 2**CYC_W-1`.
- `Clk` input 1: single clock, all state on posedge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `Start` input 1: testbench level; a high-then-low sequence launches the next program.
- `Done` input 1: processor halt indication, sampled only in RUNNING.
- `Stall` input 1: while high in RUNNING, `CountEn` is held low and the cycle counter still advances.
- `CountEn` output 1: PC increment enable.
- `LoadPC` output 1: one-cycle strobe, PC loads the start address of `ProgSel`.
- `ProgSel` output `PROG_W`: index of the current or next program.
- `Running` output 1: state is RUNNING.
- `Ack` output 1: state is HALTED (run finished; testbench may check results).
- `Timeout` output 1: last run ended by budget rather than `Done`.
- `CycleCount` output `CYC_W`: cycles spent in RUNNING for the current/last run.

## Operation
States: IDLE, ARMED, RUNNING, HALTED. The 2-bit state encoding lives in the shared package.

- **Reset** (async, `Reset_n`=0): state=IDLE.
  - `ProgSel`=0, `CycleCount`=0, `Timeout`=0, `LoadPC`=0.
  - `CountEn`=0, `Running`=0, `Ack`=0.
- **IDLE / HALTED**, `Start`=1 sampled:
  - → ARMED.
  - Clears `Timeout` and `CycleCount`.
- **ARMED**, `Start`=0 sampled:
  - → RUNNING.
  - `LoadPC`=1 for exactly that first RUNNING cycle.
  - While `Start` stays 1, remain ARMED.
- **RUNNING**:
  - `CycleCount` increments every cycle and saturates, never wraps.
  - `Done`=1 → HALTED, `Timeout`=0.
  - Else if `CycleCount`==`MAX_CYCLES`-1 → HALTED, `Timeout`=1.
  - `Done` and budget expiry on the same cycle: `Done` wins, `Timeout`=0.
  - `Start` ignored.
- **Leaving RUNNING**: `ProgSel` increments on the transition into HALTED, wrapping `NUM_PROGS`-1 → 0.
- **HALTED**: `Done` ignored.
- **Output decode**:
  - `CountEn` = `Running` & ~`Stall` & ~`LoadPC`. The PC loads, not counts, on the load cycle.
- **Structural rule**: no logic on any edge of `Start` other than the `Clk` posedge; `Start` is sampled synchronously.

## Timing
- `Start` rising seen at edge k → ARMED after k.
- `Start` falling seen at edge m → `Running`=1 and `LoadPC`=1 after m.
  - `CountEn` first high after m+1, if not stalled.
- `Done` seen at edge d → `Running`=0, `CountEn`=0, `Ack`=1 and `ProgSel`+1 after d.
  - `CycleCount` after d equals the number of RUNNING cycles, including the load cycle.
- `Timeout` and `Ack` rise together; both hold until `Start` next samples high.
- `Running`, `Ack` and `LoadPC` are registered or decoded from state only; no combinational path from inputs to any output except `Stall` → `CountEn`.
- `Reset_n` low mid-run:
  - Outputs drop to reset values immediately (asynchronously).
  - Program sequence restarts at `ProgSel`=0.

## Structure
- `prog_run_pkg`: state enum `run_state_t` {IDLE, ARMED, RUNNING, HALTED}.
  - Also a default `MAX_CYCLES` constant shared with the testbench.
- One sub-module, `sat_counter`:
  - Parameters: width and limit.
  - Ports: clear, enable, at-limit flag.
  - Used for `CycleCount`.
- `ProgSel` wrap logic stays inline.

## Test plan
- **Reset and handshake**: reset, then `Start` 1 for 3 cycles then 0 → ARMED for 3 cycles.
  - `LoadPC`=1 for one cycle with `ProgSel`=0, then `CountEn`=1.
- **Normal run**: `Done` pulsed 10 cycles after the load cycle.
  - `Ack`=1, `Timeout`=0, `CycleCount`=11, `ProgSel`=1.
- **Timeout**: `MAX_CYCLES`=8, `Done` never asserted → HALTED after 8 RUNNING cycles.
  - `Timeout`=1, `CycleCount`=7.
  - Next `Start` high clears `Timeout`.
- **Wrap and tie-break**: run 3 programs with `NUM_PROGS`=3 → `ProgSel` sequence 0, 1, 2, 0.
  - `Done` coincident with budget expiry → `Timeout`=0.
- **Stall and ignored inputs**: `Stall` high for 4 cycles mid-run → `CountEn`=0 for those 4 cycles while `CycleCount` still advances.
  - `Start` pulsed during RUNNING → no state change.
- **Async reset mid-run**: `Reset_n` low between clock edges during RUNNING → all outputs zero before the next edge.
  - Next run starts at `ProgSel`=0.

Source files
------------

// File: rtl/prog_run_pkg.sv
// ---------------------------------------------------------------------------
// prog_run_pkg
//   Shared definitions for the processor run-control block.
//   - run_state_t     : 2-bit run-control state encoding
//   - DEF_NUM_PROGS   : default number of programs run back-to-back
//   - DEF_CYC_W       : default cycle-counter width
//   - DEF_MAX_CYCLES  : default per-run cycle budget (also used by benches)
//   - prog_width()    : program-index width, never narrower than one bit
// ---------------------------------------------------------------------------
package prog_run_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    HALTED  = 2'd3
  } run_state_t;

  localparam int DEF_NUM_PROGS  = 3;
  localparam int DEF_CYC_W      = 16;
  localparam int DEF_MAX_CYCLES = 16'hFFFF;

  function automatic int prog_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_run_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up-counter that stops at LIMIT instead of wrapping.
//   Ports:
//     clk_i      : clock
//     rst_ni     : asynchronous active-low reset (count -> 0)
//     clear_i    : synchronous clear (wins over enable)
//     en_i       : count enable
//     count_o    : current count
//     at_limit_o : count has reached LIMIT
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_limit_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_limit;

  assign at_limit = (count_q == LIMIT);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !at_limit) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign at_limit_o = at_limit;

endmodule

// File: rtl/prog_run_ctrl.sv
// ---------------------------------------------------------------------------
// prog_run_ctrl
//   Start/run/halt controller for the basic processor. Launches programs
//   on a Start high-then-low handshake, drives the PC load/count enables,
//   and ends each run on Done or when the cycle budget is used up.
//   Ports:
//     Clk        : clock, all state on posedge
//     Reset_n    : asynchronous active-low reset
//     Start      : launch handshake level (sampled on Clk)
//     Done       : processor halt indication (looked at only while running)
//     Stall      : holds CountEn low while running
//     CountEn    : PC increment enable
//     LoadPC     : one-cycle PC load strobe at the start of a run
//     ProgSel    : index of the current / next program
//     Running    : a program is running
//     Ack        : run finished, results may be inspected
//     Timeout    : last run ended on the cycle budget
//     CycleCount : running cycles of the current / last run
// ---------------------------------------------------------------------------
module prog_run_ctrl
  import prog_run_pkg::*;
#(
  parameter int NUM_PROGS  = DEF_NUM_PROGS,
  parameter int PROG_W     = prog_width(NUM_PROGS),
  parameter int CYC_W      = DEF_CYC_W,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Done,
  input  logic              Stall,
  output logic              CountEn,
  output logic              LoadPC,
  output logic [PROG_W-1:0] ProgSel,
  output logic              Running,
  output logic              Ack,
  output logic              Timeout,
  output logic [CYC_W-1:0]  CycleCount
);

  // The counter parks on the last budgeted cycle; reaching it ends the run.
  localparam logic [CYC_W-1:0]  CYC_LIMIT = CYC_W'(MAX_CYCLES - 1);
  localparam logic [PROG_W-1:0] PROG_LAST = PROG_W'(NUM_PROGS - 1);

  run_state_t        state_q;
  logic [PROG_W-1:0] prog_q;
  logic [PROG_W-1:0] prog_d;
  logic              timeout_q;
  logic              load_q;
  logic              launch;
  logic              cyc_at_limit;

  // A new handshake from IDLE or HALTED clears the previous run's results.
  assign launch = ((state_q == IDLE) || (state_q == HALTED)) && Start;
  assign prog_d = (prog_q == PROG_LAST) ? '0 : prog_q + 1'b1;

  sat_counter #(
    .WIDTH (CYC_W),
    .LIMIT (CYC_LIMIT)
  ) u_cycle_cnt (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .clear_i    (launch),
    .en_i       (state_q == RUNNING),
    .count_o    (CycleCount),
    .at_limit_o (cyc_at_limit)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      prog_q    <= '0;
      timeout_q <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        IDLE, HALTED: begin
          if (Start) begin
            state_q   <= ARMED;
            timeout_q <= 1'b0;
          end
        end
        ARMED: begin
          if (!Start) begin
            state_q <= RUNNING;
            load_q  <= 1'b1;
          end
        end
        RUNNING: begin
          // Done takes priority over a budget expiry on the same cycle.
          if (Done) begin
            state_q   <= HALTED;
            timeout_q <= 1'b0;
            prog_q    <= prog_d;
          end else if (cyc_at_limit) begin
            state_q   <= HALTED;
            timeout_q <= 1'b1;
            prog_q    <= prog_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Running = (state_q == RUNNING);
  assign Ack     = (state_q == HALTED);
  assign LoadPC  = load_q;
  assign Timeout = timeout_q;
  assign ProgSel = prog_q;
  // The PC loads rather than counts on the load cycle.
  assign CountEn = Running & ~Stall & ~load_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Bench for prog_run_ctrl: two instances share the stimulus, one with the
// default cycle budget and one with a budget of 8 cycles.
module tb_prog_run_ctrl;
  import prog_run_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic done = 1'b0;
  logic stall = 1'b0;

  logic [1:0]  ce, lp, rn, ak, to;
  logic [1:0]  ps [2];
  logic [15:0] cc [2];

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  prog_run_ctrl #(.NUM_PROGS(3), .CYC_W(16), .MAX_CYCLES(DEF_MAX_CYCLES)) dut_a (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .Done(done), .Stall(stall),
    .CountEn(ce[0]), .LoadPC(lp[0]), .ProgSel(ps[0]), .Running(rn[0]),
    .Ack(ak[0]), .Timeout(to[0]), .CycleCount(cc[0]));

  prog_run_ctrl #(.NUM_PROGS(3), .CYC_W(16), .MAX_CYCLES(8)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .Done(done), .Stall(stall),
    .CountEn(ce[1]), .LoadPC(lp[1]), .ProgSel(ps[1]), .Running(rn[1]),
    .Ack(ak[1]), .Timeout(to[1]), .CycleCount(cc[1]));

  // ---------------- behavioural model ----------------
  // Each instance tracks: whether a run is in progress, whether a launch
  // is waiting for Start to drop, whether results are on show, the raw
  // number of cycles spent running, and how many runs have completed.
  int unsigned maxc [2] = '{DEF_MAX_CYCLES, 8};
  bit m_run [2] = '{0, 0};
  bit m_wait[2] = '{0, 0};
  bit m_fin [2] = '{0, 0};
  bit m_to  [2] = '{0, 0};
  int unsigned m_cyc [2] = '{0, 0};
  int unsigned m_runs[2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_run[i] <= 0; m_wait[i] <= 0; m_fin[i] <= 0; m_to[i] <= 0;
        m_cyc[i] <= 0; m_runs[i] <= 0;
      end else if (m_run[i]) begin
        m_cyc[i] <= m_cyc[i] + 1;
        if (done) begin
          m_run[i] <= 0; m_fin[i] <= 1; m_to[i] <= 0; m_runs[i] <= m_runs[i] + 1;
        end else if (m_cyc[i] >= maxc[i] - 1) begin
          m_run[i] <= 0; m_fin[i] <= 1; m_to[i] <= 1; m_runs[i] <= m_runs[i] + 1;
        end
      end else if (m_wait[i]) begin
        if (!start) begin
          m_wait[i] <= 0; m_run[i] <= 1;
        end
      end else if (start) begin
        m_wait[i] <= 1; m_fin[i] <= 0; m_to[i] <= 0; m_cyc[i] <= 0;
      end
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // One compare per instance and output on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        int unsigned e_cc;
        e_cc = (m_cyc[i] < maxc[i] - 1) ? m_cyc[i] : maxc[i] - 1;
        chk($sformatf("model_running[%0d]", i), rn[i], m_run[i]);
        chk($sformatf("model_ack[%0d]", i), ak[i], m_fin[i]);
        chk($sformatf("model_timeout[%0d]", i), to[i], m_to[i]);
        chk($sformatf("model_loadpc[%0d]", i), lp[i], m_run[i] && m_cyc[i] == 0);
        chk($sformatf("model_counten[%0d]", i), ce[i], m_run[i] && !stall && m_cyc[i] != 0);
        chk($sformatf("model_progsel[%0d]", i), ps[i], m_runs[i] % 3);
        chk($sformatf("model_cyclecount[%0d]", i), cc[i], e_cc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    cmp_en = 1'b1;
    tick(); tick(); at_neg();
    chk("rst_running", rn[0], 0); chk("rst_ack", ak[0], 0); chk("rst_timeout", to[0], 0);
    chk("rst_loadpc", lp[0], 0); chk("rst_counten", ce[0], 0); chk("rst_progsel", ps[0], 0);
    chk("rst_cyclecount", cc[0], 0);
    rst_n = 1'b1;
    tick();

    // Run 1: 3-cycle Start, Done 10 cycles after the load cycle.
    start = 1'b1; tick(); at_neg();
    chk("armed_running", rn[0], 0); chk("armed_loadpc", lp[0], 0); chk("armed_ack", ak[0], 0);
    tick(); tick(); start = 1'b0; tick(); at_neg();
    chk("r1_loadpc", lp[0], 1); chk("r1_progsel", ps[0], 0); chk("r1_load_counten", ce[0], 0);
    chk("r1_running", rn[0], 1);
    tick(); at_neg();
    chk("r1_counten", ce[0], 1); chk("r1_loadpc_off", lp[0], 0);
    repeat (9) tick();
    done = 1'b1; tick(); done = 1'b0; at_neg();
    chk("r1_ack", ak[0], 1); chk("r1_timeout", to[0], 0); chk("r1_cyclecount", cc[0], 11);
    chk("r1_progsel_next", ps[0], 1); chk("r1_running_off", rn[0], 0);
    chk("r1b_timeout", to[1], 1); chk("r1b_cyclecount", cc[1], 7); chk("r1b_ack", ak[1], 1);
    chk("r1b_progsel", ps[1], 1);

    // Run 2: Done coincides with the 8-cycle budget expiry.
    tick(); start = 1'b1; tick(); at_neg();
    chk("r2b_timeout_clr", to[1], 0); chk("r2b_cyc_clr", cc[1], 0);
    tick(); start = 1'b0; tick();
    repeat (7) tick();
    done = 1'b1; tick(); done = 1'b0; at_neg();
    chk("r2b_tie_timeout", to[1], 0); chk("r2b_tie_cyclecount", cc[1], 7); chk("r2b_ack", ak[1], 1);
    chk("r2_cyclecount", cc[0], 8); chk("r2_progsel", ps[0], 2);

    // Run 3: stall for 4 cycles, Start pulse while running; ProgSel wraps.
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("r3_stall_counten", ce[0], 0);
      if (k == 1) start = 1'b1;
      if (k == 2) start = 1'b0;
      tick();
    end
    stall = 1'b0; at_neg();
    chk("r3_counten_resume", ce[0], 1); chk("r3_running", rn[0], 1);
    done = 1'b1; tick(); done = 1'b0; at_neg();
    chk("r3_cyclecount", cc[0], 6); chk("r3_progsel_wrap", ps[0], 0); chk("r3b_progsel_wrap", ps[1], 0);

    // Run 4: short run so ProgSel moves off zero.
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    done = 1'b1; tick(); done = 1'b0; at_neg();
    chk("r4_cyclecount", cc[0], 2); chk("r4_progsel", ps[0], 1);

    // Run 5: asynchronous reset between clock edges mid-run.
    start = 1'b1; tick(); start = 1'b0; tick(); tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_running", rn[0], 0); chk("arst_counten", ce[0], 0); chk("arst_loadpc", lp[0], 0);
    chk("arst_ack", ak[0], 0); chk("arst_timeout", to[0], 0); chk("arst_progsel", ps[0], 0);
    chk("arst_cyclecount", cc[0], 0); chk("arst_b_running", rn[1], 0);
    at_neg(); rst_n = 1'b1; tick();

    // Run 6: program sequence restarts at 0.
    start = 1'b1; tick(); start = 1'b0; tick(); at_neg();
    chk("r6_loadpc", lp[0], 1); chk("r6_progsel", ps[0], 0); chk("r6_running", rn[0], 1);
    tick(); done = 1'b1; tick(); done = 1'b0; at_neg();
    chk("r6_progsel_next", ps[0], 1);
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
